// File: rtl/rtc_setup_controller_pkg.sv
// Shared constants and types for the RTC setup controller.
//   Field indices F_YEAR..F_TSEC, per-field BCD range lookup, mode
//   encoding and button bit positions used by the edge detector.
package rtc_setup_controller_pkg;

    localparam int unsigned N_FIELDS = 9;
    localparam int unsigned FIELD_W  = 8;
    localparam int unsigned IDX_W    = 4;
    localparam int unsigned N_BTN    = 7;

    typedef logic [IDX_W-1:0]   field_idx_t;
    typedef logic [FIELD_W-1:0] bcd_t;

    typedef enum logic {
        MODE_EDIT = 1'b0,
        MODE_RUN  = 1'b1
    } mode_t;

    localparam field_idx_t F_YEAR  = 4'd0;
    localparam field_idx_t F_MONTH = 4'd1;
    localparam field_idx_t F_DAY   = 4'd2;
    localparam field_idx_t F_HOUR  = 4'd3;
    localparam field_idx_t F_MIN   = 4'd4;
    localparam field_idx_t F_SEC   = 4'd5;
    localparam field_idx_t F_THOUR = 4'd6;
    localparam field_idx_t F_TMIN  = 4'd7;
    localparam field_idx_t F_TSEC  = 4'd8;

    // Bit positions inside the packed button vector.
    localparam int unsigned B_AUM   = 0;
    localparam int unsigned B_DIS   = 1;
    localparam int unsigned B_SIG   = 2;
    localparam int unsigned B_ANT   = 3;
    localparam int unsigned B_LISTO = 4;
    localparam int unsigned B_CAMB  = 5;
    localparam int unsigned B_QUITA = 6;

    // Lowest legal BCD value of a field; fmt selects 12 h hour range.
    function automatic bcd_t field_min(input field_idx_t idx, input logic fmt);
        bcd_t v;
        case (idx)
            F_MONTH, F_DAY: v = 8'h01;
            F_HOUR:         v = fmt ? 8'h01 : 8'h00;
            default:        v = 8'h00;
        endcase
        return v;
    endfunction

    // Highest legal BCD value of a field.
    function automatic bcd_t field_max(input field_idx_t idx, input logic fmt);
        bcd_t v;
        case (idx)
            F_YEAR:  v = 8'h99;
            F_MONTH: v = 8'h12;
            F_DAY:   v = 8'h31;
            F_HOUR:  v = fmt ? 8'h12 : 8'h23;
            F_THOUR: v = 8'h23;
            default: v = 8'h59;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/rtc_setup_controller_if.sv
// Button / RTC read-back / field output bundle of the RTC setup controller.
//   master: button and RTC read side (drives buttons and *le values)
//   slave : the controller (drives field values, Listo_ht, Habilita)
interface rtc_setup_controller_if;
    import rtc_setup_controller_pkg::*;

    logic aumenta;
    logic disminuye;
    logic siguiente;
    logic anterior;
    logic Listo_es;
    logic formato;
    logic cambia;
    logic quita;

    bcd_t anole, mesle, diale, horale, minle, segle, htle, mtle, stle;
    bcd_t ano, mes, dia, hora, min, seg, ht, mt, st;

    logic                Listo_ht;
    logic                modifica_timer;
    logic [N_FIELDS-1:0] Habilita;

    modport master (
        output aumenta, disminuye, siguiente, anterior, Listo_es, formato, cambia, quita,
        output anole, mesle, diale, horale, minle, segle, htle, mtle, stle,
        input  ano, mes, dia, hora, min, seg, ht, mt, st,
        input  Listo_ht, modifica_timer, Habilita
    );

    modport slave (
        input  aumenta, disminuye, siguiente, anterior, Listo_es, formato, cambia, quita,
        input  anole, mesle, diale, horale, minle, segle, htle, mtle, stle,
        output ano, mes, dia, hora, min, seg, ht, mt, st,
        output Listo_ht, modifica_timer, Habilita
    );
endinterface

// File: rtl/rtc_setup_controller_bcd_field_step.sv
// Combinational next value of one 8-bit BCD field.
//   cur          current value
//   inc/dec/clr  single-cycle action requests (clr wins; inc+dec = no change)
//   min_v/max_v  legal range of the field
//   nxt_c        resulting value
module rtc_setup_controller_bcd_field_step
    import rtc_setup_controller_pkg::*;
(
    input  bcd_t cur,
    input  logic inc,
    input  logic dec,
    input  logic clr,
    input  bcd_t min_v,
    input  bcd_t max_v,
    output bcd_t nxt_c
);

    logic in_range_c;

    // Digit validity plus range; an out-of-range value snaps to an end.
    always_comb begin
        in_range_c = (cur[3:0] <= 4'd9) && (cur[7:4] <= 4'd9) &&
                     (cur >= min_v) && (cur <= max_v);
    end

    always_comb begin
        nxt_c = cur;
        if (clr) begin
            nxt_c = min_v;
        end else if (inc && !dec) begin
            if (!in_range_c || (cur == max_v))
                nxt_c = min_v;
            else if (cur[3:0] == 4'd9)
                nxt_c = {cur[7:4] + 4'd1, 4'd0};
            else
                nxt_c = cur + 8'd1;
        end else if (dec && !inc) begin
            if (!in_range_c || (cur == min_v))
                nxt_c = max_v;
            else if (cur[3:0] == 4'd0)
                nxt_c = {cur[7:4] - 4'd1, 4'd9};
            else
                nxt_c = cur - 8'd1;
        end
    end

endmodule

// File: rtl/rtc_setup_controller.sv
// RTC date/time/timer user-edit controller.
//   clk, reset  system clock, synchronous active-high reset
//   bus         buttons, formato, RTC read-back (*le) in; nine BCD fields,
//               Listo_ht commit pulse, modifica_timer and one-hot Habilita out
// EDIT: buttons edit the selected field. RUN: fields mirror the RTC read-back.
module rtc_setup_controller
    import rtc_setup_controller_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    rtc_setup_controller_if.slave      bus
);

    bcd_t              fields [N_FIELDS];
    bcd_t              le_c   [N_FIELDS];
    field_idx_t        idx;
    mode_t             mode;
    logic [N_BTN-1:0]  btn_prev;
    logic [N_BTN-1:0]  btn_now_c;
    logic [N_BTN-1:0]  rise_c;
    logic              listo_ht_q;
    logic              mod_timer_q;
    logic [N_FIELDS-1:0] habilita_q;
    bcd_t              step_nxt_c;

    assign btn_now_c = {bus.quita, bus.cambia, bus.Listo_es, bus.anterior,
                        bus.siguiente, bus.disminuye, bus.aumenta};
    assign rise_c    = btn_now_c & ~btn_prev;

    assign le_c[F_YEAR]  = bus.anole;
    assign le_c[F_MONTH] = bus.mesle;
    assign le_c[F_DAY]   = bus.diale;
    assign le_c[F_HOUR]  = bus.horale;
    assign le_c[F_MIN]   = bus.minle;
    assign le_c[F_SEC]   = bus.segle;
    assign le_c[F_THOUR] = bus.htle;
    assign le_c[F_TMIN]  = bus.mtle;
    assign le_c[F_TSEC]  = bus.stle;

    // Next value of the currently selected field.
    rtc_setup_controller_bcd_field_step u_step (
        .cur   (fields[idx]),
        .inc   (rise_c[B_AUM]),
        .dec   (rise_c[B_DIS]),
        .clr   (rise_c[B_QUITA]),
        .min_v (field_min(idx, bus.formato)),
        .max_v (field_max(idx, bus.formato)),
        .nxt_c (step_nxt_c)
    );

    function automatic logic [N_FIELDS-1:0] onehot(input field_idx_t i);
        return 9'b1 << i;
    endfunction

    function automatic logic is_timer(input field_idx_t i);
        return i >= F_THOUR;
    endfunction

    // Mode FSM, field registers, index and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            mode        <= MODE_EDIT;
            idx         <= F_YEAR;
            btn_prev    <= '0;
            listo_ht_q  <= 1'b0;
            mod_timer_q <= 1'b0;
            habilita_q  <= onehot(F_YEAR);
            for (int i = 0; i < N_FIELDS; i++)
                fields[i] <= field_min(IDX_W'(i), 1'b0);
        end else begin
            btn_prev   <= btn_now_c;
            listo_ht_q <= 1'b0;
            case (mode)
                MODE_EDIT: begin
                    // Only the highest-priority action class present acts.
                    if (rise_c[B_LISTO]) begin
                        listo_ht_q  <= 1'b1;
                        mode        <= MODE_RUN;
                        habilita_q  <= '0;
                        mod_timer_q <= 1'b0;
                    end else if (rise_c[B_QUITA]) begin
                        fields[idx] <= step_nxt_c;
                    end else if (rise_c[B_SIG] || rise_c[B_ANT]) begin
                        if (rise_c[B_SIG] && !rise_c[B_ANT]) begin
                            idx         <= (idx == F_TSEC) ? F_YEAR : idx + 4'd1;
                            habilita_q  <= onehot((idx == F_TSEC) ? F_YEAR : idx + 4'd1);
                            mod_timer_q <= is_timer((idx == F_TSEC) ? F_YEAR : idx + 4'd1);
                        end else if (rise_c[B_ANT] && !rise_c[B_SIG]) begin
                            idx         <= (idx == F_YEAR) ? F_TSEC : idx - 4'd1;
                            habilita_q  <= onehot((idx == F_YEAR) ? F_TSEC : idx - 4'd1);
                            mod_timer_q <= is_timer((idx == F_YEAR) ? F_TSEC : idx - 4'd1);
                        end
                    end else if (rise_c[B_AUM] || rise_c[B_DIS]) begin
                        fields[idx] <= step_nxt_c;
                    end
                end
                MODE_RUN: begin
                    for (int i = 0; i < N_FIELDS; i++)
                        fields[i] <= le_c[i];
                    if (rise_c[B_CAMB]) begin
                        mode        <= MODE_EDIT;
                        idx         <= F_YEAR;
                        habilita_q  <= onehot(F_YEAR);
                        mod_timer_q <= 1'b0;
                    end
                end
                default: mode <= MODE_EDIT;
            endcase
        end
    end

    assign bus.ano            = fields[F_YEAR];
    assign bus.mes            = fields[F_MONTH];
    assign bus.dia            = fields[F_DAY];
    assign bus.hora           = fields[F_HOUR];
    assign bus.min            = fields[F_MIN];
    assign bus.seg            = fields[F_SEC];
    assign bus.ht             = fields[F_THOUR];
    assign bus.mt             = fields[F_TMIN];
    assign bus.st             = fields[F_TSEC];
    assign bus.Listo_ht       = listo_ht_q;
    assign bus.modifica_timer = mod_timer_q;
    assign bus.Habilita       = habilita_q;

endmodule

// File: tb/tb_rtc_setup_controller.sv
module tb_rtc_setup_controller;

    logic clk = 1'b0;
    logic reset;

    rtc_setup_controller_if bus ();

    rtc_setup_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    localparam int S_HAB = 9;
    localparam int S_LHT = 10;
    localparam int S_MOD = 11;

    localparam int BT_AUM = 0, BT_DIS = 1, BT_SIG = 2, BT_ANT = 3,
                   BT_LISTO = 4, BT_CAMB = 5, BT_QUITA = 6;

    typedef struct {
        int         sel;
        logic [8:0] exp;
    } sb_entry_t;

    sb_entry_t sb [$];
    string     names [12] = '{"ano", "mes", "dia", "hora", "min", "seg", "ht", "mt", "st",
                              "Habilita", "Listo_ht", "modifica_timer"};
    int checks = 0;
    int errors = 0;

    function automatic logic [8:0] obs(input int sel);
        case (sel)
            0:       return {1'b0, bus.ano};
            1:       return {1'b0, bus.mes};
            2:       return {1'b0, bus.dia};
            3:       return {1'b0, bus.hora};
            4:       return {1'b0, bus.min};
            5:       return {1'b0, bus.seg};
            6:       return {1'b0, bus.ht};
            7:       return {1'b0, bus.mt};
            8:       return {1'b0, bus.st};
            S_HAB:   return bus.Habilita;
            S_LHT:   return {8'd0, bus.Listo_ht};
            default: return {8'd0, bus.modifica_timer};
        endcase
    endfunction

    task automatic expect_v(input int sel, input logic [8:0] v);
        sb_entry_t e;
        e.sel = sel;
        e.exp = v;
        sb.push_back(e);
    endtask

    task automatic expect_all(input logic [7:0] v);
        for (int i = 0; i < 9; i++) expect_v(i, {1'b0, v});
    endtask

    // Compare every queued expectation against the DUT as it stands now.
    task automatic drain();
        sb_entry_t  e;
        logic [8:0] o;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = obs(e.sel);
            checks++;
            assert (o === e.exp) else begin
                errors++;
                $error("FAIL %s: observed %h expected %h", names[e.sel], o, e.exp);
            end
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_btn(input int b, input logic v);
        case (b)
            BT_AUM:   bus.aumenta   = v;
            BT_DIS:   bus.disminuye = v;
            BT_SIG:   bus.siguiente = v;
            BT_ANT:   bus.anterior  = v;
            BT_LISTO: bus.Listo_es  = v;
            BT_CAMB:  bus.cambia    = v;
            default:  bus.quita     = v;
        endcase
    endtask

    task automatic press(input int b, input int hold);
        set_btn(b, 1'b1);
        step(hold);
        set_btn(b, 1'b0);
        step(1);
    endtask

    task automatic press_n(input int b, input int n);
        for (int k = 0; k < n; k++) press(b, 3);
    endtask

    task automatic set_le(input logic [7:0] v);
        bus.anole = v; bus.mesle = v; bus.diale = v; bus.horale = v; bus.minle = v;
        bus.segle = v; bus.htle  = v; bus.mtle  = v; bus.stle   = v;
    endtask

    initial begin
        reset = 1'b1;
        bus.aumenta = 0; bus.disminuye = 0; bus.siguiente = 0; bus.anterior = 0;
        bus.Listo_es = 0; bus.cambia = 0; bus.quita = 0; bus.formato = 0;
        set_le(8'h00);
        step(2);

        // Reset state
        expect_v(0, 9'h000); expect_v(1, 9'h001); expect_v(2, 9'h001);
        for (int i = 3; i < 9; i++) expect_v(i, 9'h000);
        expect_v(S_HAB, 9'h001); expect_v(S_LHT, 9'h0); expect_v(S_MOD, 9'h0);
        drain();
        reset = 1'b0;
        step(1);

        // 1: eight long presses of aumenta on the year field
        for (int k = 0; k < 8; k++) press(BT_AUM, 100);
        expect_v(0, 9'h008); expect_v(S_HAB, 9'h001); expect_v(S_MOD, 9'h0);
        drain();

        // 2: walk all fields, eight increments each
        for (int i = 1; i < 9; i++) begin
            press(BT_SIG, 3);
            expect_v(S_HAB, 9'h001 << i);
            expect_v(S_MOD, (i >= 6) ? 9'h1 : 9'h0);
            drain();
            press_n(BT_AUM, 8);
        end
        press(BT_SIG, 3);
        expect_v(S_HAB, 9'h001); expect_v(S_MOD, 9'h0);
        expect_v(0, 9'h008); expect_v(1, 9'h009); expect_v(2, 9'h009);
        for (int i = 3; i < 9; i++) expect_v(i, 9'h008);
        drain();

        // 3: wrap checks
        press_n(BT_SIG, 5);                 // seconds
        press(BT_QUITA, 3);
        press(BT_DIS, 3);
        expect_v(5, 9'h059); drain();
        press(BT_AUM, 3);
        expect_v(5, 9'h000); drain();
        press_n(BT_ANT, 4);                 // month
        press(BT_QUITA, 3);
        expect_v(1, 9'h001); drain();
        press(BT_DIS, 3);
        expect_v(1, 9'h012); drain();
        press(BT_SIG, 3);                   // day
        press(BT_QUITA, 3);
        press(BT_DIS, 3);
        expect_v(2, 9'h031); drain();
        press(BT_AUM, 3);
        expect_v(2, 9'h001); drain();
        press(BT_SIG, 3);                   // hour, switch to 12 h
        bus.formato = 1'b1;
        step(2);
        expect_v(3, 9'h008); drain();       // stored value untouched
        press(BT_QUITA, 3);
        expect_v(3, 9'h001); drain();
        press(BT_DIS, 3);
        expect_v(3, 9'h012); drain();
        press(BT_AUM, 3);
        expect_v(3, 9'h001); drain();
        press_n(BT_ANT, 3);
        press(BT_ANT, 3);                   // index 0 -> 8
        expect_v(S_HAB, 9'h100); expect_v(S_MOD, 9'h1); drain();
        bus.formato = 1'b0;

        // 4: commit and run
        set_le(8'h21);
        bus.Listo_es = 1'b1;
        step(1);
        expect_v(S_LHT, 9'h1); expect_v(S_HAB, 9'h000); expect_v(S_MOD, 9'h0);
        expect_v(0, 9'h008); expect_v(5, 9'h000);
        drain();
        step(1);
        expect_v(S_LHT, 9'h0); expect_all(8'h21); drain();
        bus.Listo_es = 1'b0;
        set_le(8'h12);
        step(1);
        expect_all(8'h12); expect_v(S_LHT, 9'h0); drain();
        press(BT_AUM, 3);                   // ignored in RUN
        press(BT_QUITA, 3);
        expect_all(8'h12); expect_v(S_HAB, 9'h000); drain();

        // 5: back to EDIT from mirrored 0x21
        set_le(8'h21);
        step(1);
        press(BT_CAMB, 3);
        expect_v(S_HAB, 9'h001); expect_v(0, 9'h021); expect_v(1, 9'h021); drain();
        press_n(BT_AUM, 8);
        press(BT_SIG, 3);
        press_n(BT_AUM, 8);                 // 21 invalid -> 01, then 7 more
        press(BT_SIG, 3);
        press_n(BT_AUM, 8);
        press(BT_SIG, 3);
        bus.formato = 1'b1;                 // 12 h: 21 invalid -> 01, then 7 more
        press_n(BT_AUM, 8);
        bus.formato = 1'b0;
        expect_v(0, 9'h029); expect_v(1, 9'h008); expect_v(2, 9'h029); expect_v(3, 9'h008);
        expect_v(S_HAB, 9'h008);
        drain();
        set_le(8'h12);
        step(2);
        expect_v(0, 9'h029); expect_v(1, 9'h008); expect_v(4, 9'h021); drain();
        bus.Listo_es = 1'b1;
        step(1);
        expect_v(S_LHT, 9'h1); expect_v(0, 9'h029); drain();
        step(1);
        expect_v(S_LHT, 9'h0); expect_v(0, 9'h012); drain();
        bus.Listo_es = 1'b0;
        step(1);

        // 6: Listo_es and aumenta on the same edge
        press(BT_CAMB, 3);
        expect_v(S_HAB, 9'h001); expect_v(0, 9'h012); drain();
        bus.Listo_es = 1'b1;
        bus.aumenta  = 1'b1;
        step(1);
        expect_v(S_LHT, 9'h1); expect_v(0, 9'h012); expect_v(S_HAB, 9'h000); drain();
        step(1);
        expect_v(S_LHT, 9'h0); drain();
        bus.Listo_es = 1'b0;
        bus.aumenta  = 1'b0;
        step(1);

        // Reset mid-edit
        press(BT_CAMB, 3);
        press(BT_AUM, 3);
        expect_v(0, 9'h013); drain();
        reset = 1'b1;
        step(1);
        expect_v(0, 9'h000); expect_v(1, 9'h001); expect_v(2, 9'h001); expect_v(4, 9'h000);
        expect_v(S_HAB, 9'h001); expect_v(S_LHT, 9'h0);
        drain();
        reset = 1'b0;
        step(1);

        // Reset on the same edge as Listo_es: no commit pulse
        bus.Listo_es = 1'b1;
        reset = 1'b1;
        step(1);
        expect_v(S_LHT, 9'h0); expect_v(S_HAB, 9'h001); drain();
        bus.Listo_es = 1'b0;
        step(1);
        reset = 1'b0;
        step(2);
        expect_v(S_LHT, 9'h0); expect_v(S_HAB, 9'h001); expect_v(0, 9'h000); drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
